adc_core: RTL and testbench

- Mixed-signal front-end sequencer that sits directly upstream of the ADC APB interface.
- Decodes the interface's ADC_CTRL bus and sequences the analog macro through power-up, offset calibration and continuous 12-bit successive-approximation (SAR) conversion.
- Drives the macro's DAC, sample/hold and input-short controls; reads the macro's comparator.
- Returns ADC_PWON, ADC_RDY and ADC_B to the interface.

---
 rtl/adc_core_pkg.sv | 25 ++
 rtl/adc_core_if.sv | 29 ++
 rtl/adc_sar_engine.sv | 70 +++++++
 rtl/adc_core.sv | 162 ++++++++++++++++
 tb/tb_adc_core.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/adc_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_core_pkg
// Brief    : Shared types and constants for the ADC front-end sequencer.
// Revision : 1.0
// ============================================================================
package adc_core_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_PWRUP      = 3'd1,
    ST_STBY       = 3'd2,
    ST_CAL_SETTLE = 3'd3,
    ST_CAL_CONV   = 3'd4,
    ST_RUN        = 3'd5
  } adc_state_t;

  localparam logic [1:0] OPM_OFF = 2'b00;
  localparam logic [1:0] OPM_RUN = 2'b11;

  // One sample cycle plus one cycle per resolved bit.
  localparam int SAR_CONV_CYCLES = 13;

endpackage : adc_core_pkg
`default_nettype wire

// File: rtl/adc_core_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_core_if
// Brief    : Control/status bus between the ADC APB interface and adc_core.
// Revision : 1.0
// ============================================================================
interface adc_core_if #(
  parameter int RES_BITS = 12
);
  logic [2:0]          ADC_CTRL;
  logic                ADC_PWON;
  logic                ADC_RDY;
  logic [RES_BITS-1:0] ADC_B;

  modport master (
    output ADC_CTRL,
    input  ADC_PWON,
    input  ADC_RDY,
    input  ADC_B
  );

  modport slave (
    input  ADC_CTRL,
    output ADC_PWON,
    output ADC_RDY,
    output ADC_B
  );
endinterface : adc_core_if
`default_nettype wire

// File: rtl/adc_sar_engine.sv
`default_nettype none
// ============================================================================
// Module   : adc_sar_engine
// Brief    : Sample cycle plus bit-serial successive-approximation search.
// Revision : 1.0
// ============================================================================
module adc_sar_engine #(
  parameter int RES_BITS = 12
) (
  input  wire logic                PCLKG,
  input  wire logic                PRESETn,
  input  wire logic                start,
  input  wire logic                abort,
  input  wire logic                SAR_CMP,
  output logic                     ADC_SAMPLE,
  output logic [RES_BITS-1:0]      SAR_DAC,
  output logic                     done,
  output logic [RES_BITS-1:0]      raw
);

  localparam logic [RES_BITS-1:0] C_MSB = {1'b1, {(RES_BITS-1){1'b0}}};
  localparam logic [RES_BITS-1:0] C_LSB = {{(RES_BITS-1){1'b0}}, 1'b1};

  logic                r_sample;
  logic                r_busy;
  logic [RES_BITS-1:0] r_dac;
  logic [RES_BITS-1:0] r_mask;
  logic [RES_BITS-1:0] w_code;

  // Code after resolving the bit currently on trial.
  assign w_code = SAR_CMP ? r_dac : (r_dac & ~r_mask);
  assign done   = r_busy && (r_mask == C_LSB);
  assign raw    = w_code;

  always_ff @(posedge PCLKG or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_dac    <= '0;
      r_mask   <= '0;
    end else if (abort) begin
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_dac    <= '0;
      r_mask   <= '0;
    end else if (r_sample) begin
      r_sample <= 1'b0;
      r_busy   <= 1'b1;
      r_dac    <= C_MSB;
      r_mask   <= C_MSB;
    end else if (r_busy) begin
      if (r_mask == C_LSB) begin
        r_busy   <= 1'b0;
        r_dac    <= '0;
        r_mask   <= '0;
        r_sample <= start;
      end else begin
        r_dac  <= w_code | (r_mask >> 1);
        r_mask <= r_mask >> 1;
      end
    end else begin
      r_sample <= start;
    end
  end

  assign ADC_SAMPLE = r_sample;
  assign SAR_DAC    = r_dac;

endmodule : adc_sar_engine
`default_nettype wire

// File: rtl/adc_core.sv
`default_nettype none
// ============================================================================
// Module   : adc_core
// Brief    : Power-up, offset calibration and continuous SAR conversion sequencer.
// Revision : 1.0
// ============================================================================
module adc_core
  import adc_core_pkg::*;
#(
  parameter int PWON_CYCLES = 16,
  parameter int CAL_CYCLES  = 32,
  parameter int RES_BITS    = 12
) (
  input  wire logic                PCLKG,
  input  wire logic                PRESETn,
  adc_core_if.slave                bus,
  output logic [RES_BITS-1:0]      SAR_DAC,
  input  wire logic                SAR_CMP,
  output logic                     ADC_SAMPLE,
  output logic                     ADC_CAL_SHORT
);

  localparam int C_CNT_MAX = (PWON_CYCLES > CAL_CYCLES) ? PWON_CYCLES : CAL_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_PWON_LOAD = C_CNT_W'(PWON_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CAL_LOAD  = C_CNT_W'(CAL_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  adc_state_t          r_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic                r_pwon;
  logic                r_rdy;
  logic                r_short;
  logic                r_cal_q;
  logic [RES_BITS-1:0] r_adc_b;
  logic [RES_BITS-1:0] r_cal_offset;

  logic                w_opm_off;
  logic                w_opm_run;
  logic                w_cal_rise;
  logic                w_in_conv;
  logic                w_abort;
  logic                w_start;
  logic                w_done;
  logic [RES_BITS-1:0] w_raw;
  logic [RES_BITS-1:0] w_result;

  assign w_opm_off  = (bus.ADC_CTRL[2:1] == OPM_OFF);
  assign w_opm_run  = (bus.ADC_CTRL[2:1] == OPM_RUN);
  assign w_cal_rise = bus.ADC_CTRL[0] && !r_cal_q;
  assign w_in_conv  = (r_state == ST_CAL_CONV) || (r_state == ST_RUN);

  // Any exit from a converting state must kill the in-flight conversion on the same edge.
  assign w_abort = w_opm_off
                || (w_in_conv && !w_opm_run)
                || ((r_state == ST_RUN) && w_cal_rise);

  assign w_start = !w_abort
                && (((r_state == ST_CAL_SETTLE) && (r_cnt == '0) && w_opm_run)
                    || (w_in_conv && w_done));

  assign w_result = (w_raw >= r_cal_offset) ? (w_raw - r_cal_offset) : '0;

  adc_sar_engine #(
    .RES_BITS (RES_BITS)
  ) u_sar (
    .PCLKG      (PCLKG),
    .PRESETn    (PRESETn),
    .start      (w_start),
    .abort      (w_abort),
    .SAR_CMP    (SAR_CMP),
    .ADC_SAMPLE (ADC_SAMPLE),
    .SAR_DAC    (SAR_DAC),
    .done       (w_done),
    .raw        (w_raw)
  );

  always_ff @(posedge PCLKG or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= ST_OFF;
      r_cnt        <= '0;
      r_pwon       <= 1'b0;
      r_rdy        <= 1'b0;
      r_short      <= 1'b0;
      r_cal_q      <= 1'b0;
      r_adc_b      <= '0;
      r_cal_offset <= '0;
    end else begin
      r_cal_q <= bus.ADC_CTRL[0];
      if (w_opm_off) begin
        r_state <= ST_OFF;
        r_pwon  <= 1'b0;
        r_rdy   <= 1'b0;
        r_short <= 1'b0;
      end else begin
        unique case (r_state)
          ST_OFF: begin
            r_state <= ST_PWRUP;
            r_cnt   <= C_PWON_LOAD;
          end
          ST_PWRUP: begin
            if (r_cnt == '0) begin
              r_state <= ST_STBY;
              r_pwon  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - C_CNT_ONE;
            end
          end
          ST_STBY: begin
            if (w_opm_run) begin
              r_state <= ST_CAL_SETTLE;
              r_short <= 1'b1;
              r_cnt   <= C_CAL_LOAD;
            end
          end
          ST_CAL_SETTLE: begin
            if (!w_opm_run) begin
              r_state <= ST_STBY;
              r_short <= 1'b0;
            end else if (r_cnt == '0) begin
              r_state <= ST_CAL_CONV;
            end else begin
              r_cnt <= r_cnt - C_CNT_ONE;
            end
          end
          ST_CAL_CONV: begin
            if (!w_opm_run) begin
              r_state <= ST_STBY;
              r_short <= 1'b0;
            end else if (w_done) begin
              r_cal_offset <= w_raw;
              r_rdy        <= 1'b1;
              r_short      <= 1'b0;
              r_state      <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (!w_opm_run) begin
              r_state <= ST_STBY;
              r_rdy   <= 1'b0;
            end else if (w_cal_rise) begin
              r_state <= ST_CAL_SETTLE;
              r_rdy   <= 1'b0;
              r_short <= 1'b1;
              r_cnt   <= C_CAL_LOAD;
            end else if (w_done) begin
              r_adc_b <= w_result;
            end
          end
          default: r_state <= ST_OFF;
        endcase
      end
    end
  end

  assign bus.ADC_PWON  = r_pwon;
  assign bus.ADC_RDY   = r_rdy;
  assign bus.ADC_B     = r_adc_b;
  assign ADC_CAL_SHORT = r_short;

endmodule : adc_core
`default_nettype wire

// File: tb/tb_adc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_core
// Brief    : Directed self-checking bench for adc_core with a comparator model.
// Revision : 1.0
// ============================================================================
module tb_adc_core;
  import adc_core_pkg::*;

  logic        PCLKG;
  logic        PRESETn;
  logic [11:0] SAR_DAC;
  logic        SAR_CMP;
  logic        ADC_SAMPLE;
  logic        ADC_CAL_SHORT;
  logic [11:0] m_vin;
  logic [11:0] m_offset;
  int          n_checks;
  int          n_fail;
  int          n;
  logic        any_short;
  logic [11:0] trials [12];

  adc_core_if #(.RES_BITS(12)) bus ();

  adc_core #(
    .PWON_CYCLES (16),
    .CAL_CYCLES  (32),
    .RES_BITS    (12)
  ) dut (
    .PCLKG         (PCLKG),
    .PRESETn       (PRESETn),
    .bus           (bus),
    .SAR_DAC       (SAR_DAC),
    .SAR_CMP       (SAR_CMP),
    .ADC_SAMPLE    (ADC_SAMPLE),
    .ADC_CAL_SHORT (ADC_CAL_SHORT)
  );

  // Shorted input presents only the offset; otherwise the input already carries it.
  assign SAR_CMP = ((ADC_CAL_SHORT ? m_offset : m_vin) >= SAR_DAC);

  initial begin
    PCLKG = 1'b0;
    forever #5 PCLKG = ~PCLKG;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge PCLKG);
      #1;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       sig = bus.ADC_PWON;
      1:       sig = bus.ADC_RDY;
      2:       sig = ADC_CAL_SHORT;
      default: sig = ADC_SAMPLE;
    endcase
  endfunction

  // Returns the number of edges until the selected output equals val, or limit+1.
  task automatic edges_until(input int which, input logic val, input int limit, output int cnt);
    cnt = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      tick(1);
      if (sig(which) == val) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    trials = '{12'h800, 12'h400, 12'h600, 12'h500, 12'h580, 12'h5C0,
               12'h5A0, 12'h5B0, 12'h5A8, 12'h5A4, 12'h5A2, 12'h5A3};
    PRESETn      = 1'b0;
    bus.ADC_CTRL = 3'b000;
    m_offset     = 12'h010;
    m_vin        = 12'h5A3;

    tick(3);
    check("reset_flags", {30'd0, bus.ADC_PWON, bus.ADC_RDY}, 32'd0);
    check("reset_b", {20'd0, bus.ADC_B}, 32'd0);
    check("reset_dac", {20'd0, SAR_DAC}, 32'd0);
    check("reset_sample_short", {30'd0, ADC_SAMPLE, ADC_CAL_SHORT}, 32'd0);
    PRESETn = 1'b1;
    tick(2);

    // Power-up: entry edge, then PWON 16 edges later, calibration 45 edges after STBY exit.
    bus.ADC_CTRL = 3'b110;
    tick(1);
    check("pwon_low_at_entry", {31'd0, bus.ADC_PWON}, 32'd0);
    edges_until(0, 1'b1, 40, n);
    check("pwon_latency", n, 16);
    edges_until(2, 1'b1, 10, n);
    check("stby_exit_latency", n, 1);
    edges_until(2, 1'b0, 100, n);
    check("cal_short_cycles", n, 45);
    check("rdy_with_short_fall", {31'd0, bus.ADC_RDY}, 32'd1);
    check("first_sample", {31'd0, ADC_SAMPLE}, 32'd1);
    check("b_before_first", {20'd0, bus.ADC_B}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check($sformatf("dac_trial_%0d", i), {20'd0, SAR_DAC}, {20'd0, trials[i]});
    end
    tick(1);
    check("b_first_result", {20'd0, bus.ADC_B}, 32'h593);
    check("dac_after_done", {20'd0, SAR_DAC}, 32'd0);
    check("sample_back_to_back", {31'd0, ADC_SAMPLE}, 32'd1);

    m_vin = 12'h123;
    tick(SAR_CONV_CYCLES - 1);
    check("b_held_between", {20'd0, bus.ADC_B}, 32'h593);
    tick(1);
    check("b_second_result", {20'd0, bus.ADC_B}, 32'h113);

    // Recalibration with a larger offset, then a sub-offset input must clamp at 0.
    m_offset     = 12'h020;
    m_vin        = 12'h010;
    bus.ADC_CTRL = 3'b111;
    tick(1);
    check("recal_rdy_drop", {31'd0, bus.ADC_RDY}, 32'd0);
    check("recal_short", {31'd0, ADC_CAL_SHORT}, 32'd1);
    check("recal_abort_dac", {20'd0, SAR_DAC}, 32'd0);
    edges_until(1, 1'b1, 100, n);
    check("recal_rdy_latency", n, 45);
    tick(SAR_CONV_CYCLES);
    check("saturate_zero", {20'd0, bus.ADC_B}, 32'd0);
    any_short = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      any_short = any_short | ADC_CAL_SHORT | !bus.ADC_RDY;
    end
    check("cal_held_no_retrigger", {31'd0, any_short}, 32'd0);

    // Now one edge into a conversion's bit phase; it resolves 0x300 - 0x020.
    m_vin = 12'h300;
    tick(12);
    check("b_after_recal", {20'd0, bus.ADC_B}, 32'h2E0);

    tick(6);
    bus.ADC_CTRL = 3'b000;
    tick(1);
    check("pdown_flags", {30'd0, bus.ADC_PWON, bus.ADC_RDY}, 32'd0);
    check("pdown_dac_sample", {19'd0, SAR_DAC, ADC_SAMPLE}, 32'd0);
    check("pdown_b_kept", {20'd0, bus.ADC_B}, 32'h2E0);

    m_vin = 12'h400;
    tick(2);
    bus.ADC_CTRL = 3'b110;
    tick(1);
    edges_until(0, 1'b1, 40, n);
    check("repower_pwon_latency", n, 16);
    edges_until(1, 1'b1, 100, n);
    check("repower_rdy_latency", n, 46);
    tick(SAR_CONV_CYCLES);
    check("repower_result", {20'd0, bus.ADC_B}, 32'h3E0);

    // Asynchronous reset in the middle of a calibration.
    bus.ADC_CTRL = 3'b111;
    tick(20);
    check("midcal_short", {31'd0, ADC_CAL_SHORT}, 32'd1);
    #3;
    PRESETn = 1'b0;
    #1;
    check("async_rst_flags", {28'd0, bus.ADC_PWON, bus.ADC_RDY, ADC_SAMPLE, ADC_CAL_SHORT}, 32'd0);
    check("async_rst_b", {20'd0, bus.ADC_B}, 32'd0);
    check("async_rst_dac", {20'd0, SAR_DAC}, 32'd0);
    check("async_rst_cal_offset", {20'd0, dut.r_cal_offset}, 32'd0);
    check("async_rst_state", {29'd0, dut.r_state}, {29'd0, ST_OFF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adc_core
`default_nettype wire
